// File: rtl/ping_pong_pkg.sv
// Shared constants for the ping-pong counter seven-segment display.
// The package holds the active-low segment codes, the UP/DOWN/blank patterns and the digit indices.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    DigitOnes  = 2'd0,
    DigitTens  = 2'd1,
    DigitBlank = 2'd2,
    DigitDir   = 2'd3
  } digit_e;

  typedef struct packed {
    logic [3:0] value;
    logic       direction;
    logic       enable;
  } snap_t;

  // Segment order is {g,f,e,d,c,b,a}, and all outputs are active-low.
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegUp    = 7'b1011100;
  localparam logic [6:0] SegDown  = 7'b1100011;
  localparam logic [3:0] AnOff    = 4'b1111;

  localparam snap_t SnapReset = '{value: 4'd0, direction: 1'b1, enable: 1'b0};

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SegBlank;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ping_pong_seg_display_if.sv
// This file bundles the display's upstream counter inputs and its drive outputs.
// The master side feeds the counter state, and the slave side drives the digits.
interface ping_pong_seg_display_if;
  logic [3:0] value;
  logic       direction;
  logic       enable;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output value, direction, enable,
    input  an, seg, dp
  );

  modport slave (
    input  value, direction, enable,
    output an, seg, dp
  );
endinterface

// File: rtl/ping_pong_seg_decoder.sv
// This is a combinational decoder that turns the selected digit index and the snapshot into
// active-low digit-enable, segment and decimal-point drive.
module ping_pong_seg_decoder
  import ping_pong_pkg::*;
(
  input  digit_e     digit_i,
  input  logic [3:0] value_i,
  input  logic       direction_i,
  input  logic       enable_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  logic       tens;
  logic [3:0] ones;

  always_comb begin
    tens  = (value_i >= 4'd10);
    ones  = tens ? (value_i - 4'd10) : value_i;
    an_o  = ~(4'b0001 << digit_i);
    seg_o = SegBlank;
    dp_o  = 1'b1;
    unique case (digit_i)
      DigitOnes:  seg_o = seg_code(ones);
      DigitTens:  seg_o = tens ? seg_code(4'd1) : SegBlank;
      DigitBlank: seg_o = SegBlank;
      DigitDir: begin
        seg_o = direction_i ? SegUp : SegDown;
        dp_o  = ~enable_i;
      end
    endcase
  end

endmodule

// File: rtl/ping_pong_seg_display.sv
// This module drives a four-digit multiplexed display of the ping-pong counter's value, direction and run state.
// The inputs are sampled only at frame boundaries, so every frame is internally consistent.
module ping_pong_seg_display
  import ping_pong_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       direction,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  digit_e                  scan_q, scan_d;
  snap_t                   snap_q, snap_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick;

  always_comb begin
    cnt_d  = cnt_q + REFRESH_BITS'(1);
    tick   = &cnt_q;
    scan_d = tick ? digit_e'(scan_q + 2'd1) : scan_q;
    snap_d = snap_q;
    // The frame boundary is the last tick of digit 3, so the next frame starts on fresh data.
    if (tick && (scan_q == DigitDir)) begin
      snap_d = '{value: value, direction: direction, enable: enable};
    end
  end

  ping_pong_seg_decoder u_decoder (
    .digit_i     (scan_q),
    .value_i     (snap_q.value),
    .direction_i (snap_q.direction),
    .enable_i    (snap_q.enable),
    .an_o        (an_d),
    .seg_o       (seg_d),
    .dp_o        (dp_d)
  );

  // The rst_n port is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q  <= '0;
      scan_q <= DigitOnes;
      snap_q <= SnapReset;
      an_q   <= AnOff;
      seg_q  <= SegBlank;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/ping_pong_seg_display.md
PING_PONG_SEG_DISPLAY -- requirements
Module: ping_pong_seg_display

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports and parameters SHALL be exactly those listed below.
REQ-002 Parameter: REFRESH_BITS, 17, width of the refresh counter; the display advances one digit per 2^REFRESH_BITS cycles (sim value 2).
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  synchronous reset, active-high: a 1 sampled at a rising edge of clk resets the block.
REQ-005 Port: value  input  4  counter value from the upstream ping-pong counter (0..15).
REQ-006 Port: direction  input  1  counter direction from upstream (1 = up, 0 = down).
REQ-007 Port: enable  input  1  counter enable from upstream; drives the running indicator.
REQ-008 Port: an  output  4  digit enables, active-low; an[i] = 0 selects digit i.
REQ-009 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port: dp  output  1  decimal point, active-low.

Function
REQ-011 The refresh counter SHALL increment by 1 every cycle and wrap from all-ones to 0; the wrap cycle is a "tick".
REQ-012 The scan index SHALL advance 0->1->2->3->0 on each tick and hold otherwise.
REQ-013 On a tick with scan index 3 (frame boundary), the block SHALL capture value, direction and enable into a snapshot; the snapshot SHALL hold between boundaries.
REQ-014 The display SHALL derive only from the snapshot, never directly from inputs; no frame SHALL show mixed old/new digits.
REQ-015 Digit 0: ones digit of snapshot value (value mod 10).
REQ-016 Digit 1: "1" when snapshot value >= 10, blank otherwise (leading-zero suppression).
REQ-017 Digit 2: always blank.
REQ-018 Digit 3: UP pattern 1011100 when snapshot direction = 1, DOWN pattern 1100011 when 0.
REQ-019 dp SHALL be 0 only while digit 3 is selected and snapshot enable = 1; 1 otherwise.
REQ-020 Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-021 an, seg and dp SHALL be registered, reflecting scan index and snapshot with one cycle of latency; exactly one an bit SHALL be 0 outside reset.
REQ-022 Worst-case input-to-display latency: 4*2^REFRESH_BITS + 1 cycles; a change is visible one cycle after the next frame boundary.

Reset
REQ-023 While rst_n = 1: refresh counter = 0, scan index = 0, snapshot value = 0, direction = 1, enable = 0, an = 1111, seg = 1111111, dp = 1.
REQ-024 On the first edge after reset release: an = 1110, seg = 1000000, dp = 1.
REQ-025 Reset asserted mid-frame SHALL take effect at the next edge, discarding the partial scan and restarting at digit 0.

Structure
REQ-026 Segment codes, UP/DOWN/blank patterns and digit-index constants SHALL be in shared package ping_pong_pkg.
REQ-027 Value-to-digit decoding (mod-10 split, code lookup) SHALL be in combinational sub-module ping_pong_seg_decoder; counter, scan index, snapshot and output registers stay in the top.

Verification (REFRESH_BITS = 2: 4 cycles per digit, 16 per frame)
REQ-028 Reset held 3 cycles -> an = 1111, seg = 1111111, dp = 1 throughout; first edge after release -> an = 1110, seg = 1000000.
REQ-029 Free run -> an sequence 1110, 1101, 1011, 0111, each for 4 cycles, period 16, never two digits low.
REQ-030 value = 13, direction = 1, enable = 1 applied mid-frame -> display unchanged until boundary; next frame: digit0 = 0110000, digit1 = 1111001, digit2 = 1111111, digit3 = 1011100 with dp = 0.
REQ-031 value = 7, direction = 0, enable = 0 -> digit0 = 1111000, digit1 blank, digit3 = 1100011, dp = 1; value = 0 -> digit0 = 1000000.
REQ-032 value toggling 3/12 every cycle -> each frame shows only the value sampled at its boundary; digits 0 and 1 always consistent.
REQ-033 rst_n pulsed for 1 cycle while digit 2 is displayed -> next edge all off, snapshot cleared; following edge an = 1110, seg = 1000000.
